// File: rtl/vga_pkg.sv
// Shared VGA timing constants (800x600 @ 36 MHz pixel clock).
// The DEF_* values are the default module timing. The game logic imports the
// HLastActive/VLastActive values for its 799/599 end-of-frame check.
package vga_pkg;

  localparam int unsigned DefHActive = 800;
  localparam int unsigned DefHFp     = 24;
  localparam int unsigned DefHSync   = 72;
  localparam int unsigned DefHBp     = 128;
  localparam int unsigned DefVActive = 600;
  localparam int unsigned DefVFp     = 1;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 22;

  localparam int unsigned DefHTotal = DefHActive + DefHFp + DefHSync + DefHBp;  // 1024
  localparam int unsigned DefVTotal = DefVActive + DefVFp + DefVSync + DefVBp;  // 625

  localparam int unsigned HLastActive = DefHActive - 1;  // 799
  localparam int unsigned VLastActive = DefVActive - 1;  // 599

  localparam int unsigned HCoordW = 11;
  localparam int unsigned VCoordW = 10;

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing generator with registered colour/sync output stage.
// Ports:
//   pixel_clk               pixel clock, all logic on the rising edge
//   rst_n                   asynchronous active-low reset
//   red_in/green_in/blue_in colour for the current h_coord/v_coord
//   h_coord/v_coord         raster counters (the counter flops themselves)
//   display_on              coords lie inside the visible area
//   frame_start             one-cycle pulse while coords are (0,0)
//   vga_hs/vga_vs           sync outputs, aligned with vga_r/g/b
//   vga_r/vga_g/vga_b       registered colour to the DAC
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  input  logic [3:0]         red_in,
  input  logic [3:0]         green_in,
  input  logic [3:0]         blue_in,
  output logic [HCoordW-1:0] h_coord,
  output logic [VCoordW-1:0] v_coord,
  output logic               display_on,
  output logic               frame_start,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HCoordW-1:0] HLast    = HCoordW'(HTotal - 1);
  localparam logic [HCoordW-1:0] HActEnd  = HCoordW'(H_ACTIVE);
  localparam logic [HCoordW-1:0] HsStart  = HCoordW'(H_ACTIVE + H_FP);
  localparam logic [HCoordW-1:0] HsEnd    = HCoordW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCoordW-1:0] VLast    = VCoordW'(VTotal - 1);
  localparam logic [VCoordW-1:0] VActEnd  = VCoordW'(V_ACTIVE);
  localparam logic [VCoordW-1:0] VsStart  = VCoordW'(V_ACTIVE + V_FP);
  localparam logic [VCoordW-1:0] VsEnd    = VCoordW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HCoordW-1:0] h_q, h_d;
  logic [VCoordW-1:0] v_q, v_d;
  logic               display_on_q, display_on_d;
  logic               frame_start_q, frame_start_d;
  // Internal syncs, active-high, aligned with the coordinate registers.
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               vga_hs_q, vga_hs_d;
  logic               vga_vs_q, vga_vs_d;
  logic [3:0]         vga_r_q, vga_r_d;
  logic [3:0]         vga_g_q, vga_g_d;
  logic [3:0]         vga_b_q, vga_b_d;
  logic               h_wrap;

  always_comb begin
    h_wrap = (h_q == HLast);
    h_d    = h_wrap ? '0 : h_q + 1'b1;
    v_d    = v_q;
    if (h_wrap) begin
      v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
    end

    // Decode from the next counter values so the flags land with their coords.
    display_on_d  = (h_d < HActEnd) && (v_d < VActEnd);
    frame_start_d = (h_d == '0) && (v_d == '0);
    hsync_d       = (h_d >= HsStart) && (h_d < HsEnd);
    vsync_d       = (v_d >= VsStart) && (v_d < VsEnd);

    // Output stage: one cycle behind the coords, colour gated by display_on.
    vga_hs_d = hsync_q ? HS_POL : ~HS_POL;
    vga_vs_d = vsync_q ? VS_POL : ~VS_POL;
    vga_r_d  = display_on_q ? red_in   : '0;
    vga_g_d  = display_on_q ? green_in : '0;
    vga_b_d  = display_on_q ? blue_in  : '0;
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      display_on_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      vga_hs_q      <= ~HS_POL;
      vga_vs_q      <= ~VS_POL;
      vga_r_q       <= '0;
      vga_g_q       <= '0;
      vga_b_q       <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      display_on_q  <= display_on_d;
      frame_start_q <= frame_start_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vga_hs_q      <= vga_hs_d;
      vga_vs_q      <= vga_vs_d;
      vga_r_q       <= vga_r_d;
      vga_g_q       <= vga_g_d;
      vga_b_q       <= vga_b_d;
    end
  end

  assign h_coord     = h_q;
  assign v_coord     = v_q;
  assign display_on  = display_on_q;
  assign frame_start = frame_start_q;
  assign vga_hs      = vga_hs_q;
  assign vga_vs      = vga_vs_q;
  assign vga_r       = vga_r_q;
  assign vga_g       = vga_g_q;
  assign vga_b       = vga_b_q;

endmodule

// File: tb/tb_vga_timing.sv
// Testbench for vga_timing: a default-timing instance (table vectors and a
// per-cycle arithmetic model) plus a shrunken, negative-polarity instance so
// whole frames, vsync and frame_start periods fit in a short run.
module tb_vga_timing;

  logic       pixel_clk = 1'b0;
  logic       rst_n     = 1'b0;
  logic [3:0] red_in    = 4'hF;
  logic [3:0] green_in  = 4'h0;
  logic [3:0] blue_in   = 4'hA;

  logic [10:0] d_h, s_h;
  logic [9:0]  d_v, s_v;
  logic        d_disp, d_fs, d_hs, d_vs, s_disp, s_fs, s_hs, s_vs;
  logic [3:0]  d_r, d_g, d_b, s_r, s_g, s_b;

  always #5 pixel_clk = ~pixel_clk;

  vga_timing dut_d (
    .pixel_clk   (pixel_clk),
    .rst_n       (rst_n),
    .red_in      (red_in),
    .green_in    (green_in),
    .blue_in     (blue_in),
    .h_coord     (d_h),
    .v_coord     (d_v),
    .display_on  (d_disp),
    .frame_start (d_fs),
    .vga_hs      (d_hs),
    .vga_vs      (d_vs),
    .vga_r       (d_r),
    .vga_g       (d_g),
    .vga_b       (d_b)
  );

  vga_timing #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .HS_POL   (1'b0), .VS_POL (1'b0)
  ) dut_s (
    .pixel_clk   (pixel_clk),
    .rst_n       (rst_n),
    .red_in      (red_in),
    .green_in    (green_in),
    .blue_in     (blue_in),
    .h_coord     (s_h),
    .v_coord     (s_v),
    .display_on  (s_disp),
    .frame_start (s_fs),
    .vga_hs      (s_hs),
    .vga_vs      (s_vs),
    .vga_r       (s_r),
    .vga_g       (s_g),
    .vga_b       (s_b)
  );

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
  } tim_t;

  typedef struct {
    int          h;
    int          v;
    bit          d;
    bit          fs;
    bit          hs;
    bit          vs;
    logic [11:0] rgb;
  } exp_t;

  typedef struct {
    int          n;
    int          h;
    int          v;
    bit          d;
    bit          fs;
    bit          hs;
    bit          vs;
    logic [11:0] rgb;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl[NV];

  tim_t t_d = '{800, 24, 72, 128, 600, 1, 2, 22, 1'b1, 1'b1};
  tim_t t_s = '{8, 2, 3, 3, 4, 1, 2, 1, 1'b0, 1'b0};

  int checks   = 0;
  int failures = 0;
  int n        = 0;  // rising edges since reset release
  int ti       = 1;
  int d_hs_cnt, s_hs_cnt, s_vs_cnt, s_fs_last, s_fs_seen;

  // Expected outputs n edges after release, derived from raster arithmetic.
  function automatic exp_t model(tim_t t, int k);
    exp_t e;
    int   ht, vt, ph, pv;
    bit   ah, av, pd;
    ht   = t.ha + t.hf + t.hs + t.hb;
    vt   = t.va + t.vf + t.vs + t.vb;
    e.h  = k % ht;
    e.v  = (k / ht) % vt;
    e.d  = (k >= 1) && (e.h < t.ha) && (e.v < t.va);
    e.fs = (k >= 1) && (e.h == 0) && (e.v == 0);
    ah   = 1'b0;
    av   = 1'b0;
    pd   = 1'b0;
    if (k >= 2) begin
      ph = (k - 1) % ht;
      pv = ((k - 1) / ht) % vt;
      ah = (ph >= t.ha + t.hf) && (ph < t.ha + t.hf + t.hs);
      av = (pv >= t.va + t.vf) && (pv < t.va + t.vf + t.vs);
      pd = (ph < t.ha) && (pv < t.va);
    end
    e.hs  = ah ? t.hp : !t.hp;
    e.vs  = av ? t.vp : !t.vp;
    e.rgb = pd ? 12'hF0A : 12'h000;
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s n=%0d actual=%0d required=%0d", nm, n, act, req);
    end
  endtask

  task automatic check_out(string tag, exp_t e, logic [10:0] h, logic [9:0] v, logic dp,
                           logic fs, logic hs, logic vs, logic [11:0] rgb);
    chk({tag, ".h_coord"}, 32'(h), e.h);
    chk({tag, ".v_coord"}, 32'(v), e.v);
    chk({tag, ".display_on"}, 32'(dp), 32'(e.d));
    chk({tag, ".frame_start"}, 32'(fs), 32'(e.fs));
    chk({tag, ".vga_hs"}, 32'(hs), 32'(e.hs));
    chk({tag, ".vga_vs"}, 32'(vs), 32'(e.vs));
    chk({tag, ".rgb"}, 32'(rgb), 32'(e.rgb));
  endtask

  function automatic exp_t vec_exp(vec_t x);
    exp_t e;
    e.h   = x.h;
    e.v   = x.v;
    e.d   = x.d;
    e.fs  = x.fs;
    e.hs  = x.hs;
    e.vs  = x.vs;
    e.rgb = x.rgb;
    return e;
  endfunction

  task automatic check_reset_state(string tag);
    check_out({tag, ".def"}, vec_exp(tbl[0]), d_h, d_v, d_disp, d_fs, d_hs, d_vs,
              {d_r, d_g, d_b});
    check_out({tag, ".small"}, model(t_s, 0), s_h, s_v, s_disp, s_fs, s_hs, s_vs,
              {s_r, s_g, s_b});
  endtask

  task automatic step();
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    n++;
  endtask

  task automatic release_reset();
    #2 rst_n = 1'b1;
    n         = 0;
    ti        = 1;
    d_hs_cnt  = 0;
    s_hs_cnt  = 0;
    s_vs_cnt  = 0;
    s_fs_last = 0;
    s_fs_seen = 0;
  endtask

  task automatic run_phase(int cycles);
    for (int k = 0; k < cycles; k++) begin
      step();
      check_out("def", model(t_d, n), d_h, d_v, d_disp, d_fs, d_hs, d_vs, {d_r, d_g, d_b});
      check_out("small", model(t_s, n), s_h, s_v, s_disp, s_fs, s_hs, s_vs, {s_r, s_g, s_b});
      if (ti < NV && tbl[ti].n == n) begin
        check_out($sformatf("tbl%0d", ti), vec_exp(tbl[ti]), d_h, d_v, d_disp, d_fs, d_hs,
                  d_vs, {d_r, d_g, d_b});
        ti++;
      end
      // Sync pulse widths per line / per frame, and frame_start period.
      if (d_hs === 1'b1) d_hs_cnt++;
      if (d_h == 11'd0) begin
        chk("def.hs_per_line", d_hs_cnt, 72);
        d_hs_cnt = 0;
      end
      if (s_hs === 1'b0) s_hs_cnt++;
      if (s_h == 11'd0) begin
        chk("small.hs_per_line", s_hs_cnt, 3);
        s_hs_cnt = 0;
      end
      if (s_vs === 1'b0) s_vs_cnt++;
      if (s_fs === 1'b1) begin
        chk("small.fs_period", n - s_fs_last, 128);
        chk("small.vs_per_frame", s_vs_cnt, 32);
        s_fs_last = n;
        s_vs_cnt  = 0;
        s_fs_seen++;
      end
    end
    chk("tbl.applied", ti, NV);
    chk("small.fs_count", s_fs_seen, cycles / 128);
  endtask

  initial begin
    tbl[0]  = '{0,    0,    0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
    tbl[1]  = '{1,    1,    0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000};
    tbl[2]  = '{2,    2,    0, 1'b1, 1'b0, 1'b0, 1'b0, 12'hF0A};
    tbl[3]  = '{799,  799,  0, 1'b1, 1'b0, 1'b0, 1'b0, 12'hF0A};
    tbl[4]  = '{800,  800,  0, 1'b0, 1'b0, 1'b0, 1'b0, 12'hF0A};
    tbl[5]  = '{801,  801,  0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
    tbl[6]  = '{824,  824,  0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
    tbl[7]  = '{825,  825,  0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
    tbl[8]  = '{896,  896,  0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
    tbl[9]  = '{897,  897,  0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
    tbl[10] = '{1023, 1023, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
    tbl[11] = '{1024, 0,    1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000};
    tbl[12] = '{1025, 1,    1, 1'b1, 1'b0, 1'b0, 1'b0, 12'hF0A};

    // Power-on reset held across several edges.
    repeat (4) @(negedge pixel_clk);
    check_reset_state("por");
    release_reset();

    // Two and a half lines: ends with the default raster at h=500, v=2.
    run_phase(2548);
    chk("pre_reset.h", 32'(d_h), 500);

    // Asynchronous reset between edges must clear outputs before any edge.
    #2 rst_n = 1'b0;
    #1 check_reset_state("async");
    @(negedge pixel_clk);
    check_reset_state("held");
    release_reset();
    run_phase(1100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Parameters
- H_ACTIVE, default 800, visible pixels per line.
- H_FP, default 24, horizontal front porch in pixels.
- H_SYNC, default 72, horizontal sync width in pixels.
- H_BP, default 128, horizontal back porch in pixels.
- V_ACTIVE, default 600, visible lines per frame.
- V_FP, default 1, vertical front porch in lines.
- V_SYNC, default 2, vertical sync width in lines.
- V_BP, default 22, vertical back porch in lines.
- HS_POL, default 1, hsync active level.
- VS_POL, default 1, vsync active level.

Interface
REQ-001 pixel_clk  in  1  pixel clock, 36 MHz; the only clock; all logic rising-edge.
REQ-002 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-003 red_in, green_in, blue_in  in  4 each  pixel colour for the current h_coord/v_coord.
REQ-004 h_coord  out  11  current horizontal count, 0..H_TOTAL-1.
REQ-005 v_coord  out  10  current vertical count, 0..V_TOTAL-1.
REQ-006 display_on  out  1  high when h_coord<H_ACTIVE and v_coord<V_ACTIVE.
REQ-007 frame_start  out  1  single-cycle pulse when h_coord=0 and v_coord=0.
REQ-008 vga_hs, vga_vs  out  1 each  sync outputs, aligned to the colour outputs.
REQ-009 vga_r, vga_g, vga_b  out  4 each  registered colour to the DAC.

Function
REQ-010 H_TOTAL and V_TOTAL SHALL be the sum of active, front porch, sync and back porch; defaults are 1024 and 625.
REQ-011 The horizontal counter SHALL increment every cycle and wrap from H_TOTAL-1 to 0.
REQ-012 The vertical counter SHALL increment only on the cycle the horizontal counter wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same cycle.
REQ-013 h_coord and v_coord SHALL be the counter registers themselves, with no combinational path to the outputs.
REQ-014 display_on and frame_start SHALL be registered and coincide with the h_coord/v_coord value they describe.
REQ-015 Internal hsync SHALL be active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; default range is 824..895.
REQ-016 Internal vsync SHALL be active for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC; default lines are 601..602, and it spans whole lines.
REQ-017 Colour path: on each edge, vga_r/g/b SHALL load red_in/green_in/blue_in when display_on is high, otherwise 0; fixed latency is 1 cycle from coords.
REQ-018 vga_hs and vga_vs SHALL be delayed by the same 1 cycle, so sync and colour leave on the same edge.
REQ-019 Active sync level SHALL equal HS_POL/VS_POL; the inactive level is the inverse.
REQ-020 frame_start SHALL pulse exactly once per V_TOTAL*H_TOTAL cycles (640000 by default).

Reset
REQ-021 While rst_n=0, the following SHALL hold:
- h_coord=0 and v_coord=0.
- display_on=0 and frame_start=0.
- vga_r/g/b=0.
- vga_hs and vga_vs at their inactive level.
REQ-022 Reset asserted mid-line or mid-frame SHALL clear state immediately, without waiting for a clock edge.
REQ-023 On the first edge after release, counters SHALL advance to h=1, v=0, so the first full frame starts at the release point.
REQ-024 No output SHALL glitch to its active level during reset release.

Structure
REQ-025 A shared package vga_pkg SHALL hold the default timing constants and the derived H_TOTAL/V_TOTAL; game logic uses the same constants for its 799/599 end-of-frame check.
REQ-026 There SHALL be no sub-module: both counters, the sync decode and the output register stage stay inline.

Verification
REQ-027 Reset release, then run 1024 cycles: expect h_coord 0..1023 then 0, with v_coord incrementing to 1 exactly at the wrap.
REQ-028 Run one full frame:
- expect vga_hs high for 72 cycles per line, first high one cycle after h_coord=824;
- expect vga_vs high for 2048 cycles, from line 601;
- expect frame_start period 640000.
REQ-029 Drive red_in=F, green_in=0, blue_in=A constantly:
- expect vga_r/g/b = F/0/A one cycle after coords enter (0,0) through (799,599);
- expect 0 at h_coord=800..1023 and on lines 600..624.
REQ-030 Assert rst_n low at h=500, v=300, between edges: expect all outputs at reset values immediately; after release expect the sequence of REQ-027.
REQ-031 Set HS_POL=0 and VS_POL=0: expect idle-high syncs, low during the REQ-028 windows, colour timing unchanged.
